// File: rtl/pipeline_defs_pkg.sv
// Shared decode/execute definitions: opcodes, ALU operations and the control bundle.
// The BUBBLE_CNT_EN build option lives in id_ex_stage; nothing here depends on it.
package pipeline_defs_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FUNCT_W  = 4;
    localparam int unsigned ALUOP_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h7;

    typedef struct packed {
        logic               reg_write;
        logic               branch;
        logic               jump;
        logic               halt;
        logic               write_op2;
        logic               mem_read;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    localparam ctrl_t BUBBLE = '0;

    // An empty ID slot must never carry live control into EX.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        return valid ? c : BUBBLE;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use / halt hazard detection; also drives the IF/ID hold input.
module hazard_detect #(
    parameter int unsigned REG_AW = 4
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_halt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              branch_taken_i,
    input  logic              halted_i,
    output logic              load_use_o,
    output logic              halt_pend_o,
    output logic              hazard_stall_o
);

    logic rd_match;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign rd_match = (ex_rd_i != '0) && ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

    assign load_use_o     = ex_valid_i & ex_mem_read_i & id_valid_i & rd_match;
    assign halt_pend_o    = ex_valid_i & ex_halt_i;
    assign hazard_stall_o = (load_use_o & ~branch_taken_i) | halt_pend_o | halted_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, stall hold and halt.
// Build option BUBBLE_CNT_EN adds a saturating BubbleCount of flush and load-use bubbles.
module id_ex_stage
    import pipeline_defs_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned PC_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                IdValid,
    input  logic [OPCODE_W-1:0] IdOpcode,
    input  logic [FUNCT_W-1:0]  IdFunct,
    input  logic [REG_AW-1:0]   IdRs,
    input  logic [REG_AW-1:0]   IdRt,
    input  logic [REG_AW-1:0]   IdRd,
    input  logic [DATA_W-1:0]   IdData1,
    input  logic [DATA_W-1:0]   IdData2,
    input  logic [DATA_W-1:0]   IdImm,
    input  logic [PC_W-1:0]     IdPC,
    input  logic                RegWrite,
    input  logic                Branch,
    input  logic                Jump,
    input  logic                Halt,
    input  logic                WriteOP2,
    input  logic                MemRead,
    input  logic [ALUOP_W-1:0]  ALUOP,
    input  logic                ExStall,
    input  logic                BranchTaken,
    output logic                ExValid,
    output logic [OPCODE_W-1:0] ExOpcode,
    output logic [FUNCT_W-1:0]  ExFunct,
    output logic [ALUOP_W-1:0]  ExALUOP,
    output logic [REG_AW-1:0]   ExRd,
    output logic [DATA_W-1:0]   ExData1,
    output logic [DATA_W-1:0]   ExData2,
    output logic [DATA_W-1:0]   ExImm,
    output logic [PC_W-1:0]     ExPC,
    output logic                ExRegWrite,
    output logic                ExBranch,
    output logic                ExJump,
    output logic                ExHalt,
    output logic                ExWriteOP2,
    output logic                ExMemRead,
    output logic                HazardStall,
    output logic                Halted
`ifdef BUBBLE_CNT_EN
    ,
    output logic [15:0]         BubbleCount
`endif
);

    logic                valid_q,  valid_d;
    ctrl_t               ctrl_q,   ctrl_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [FUNCT_W-1:0]  funct_q,  funct_d;
    logic [REG_AW-1:0]   rd_q,     rd_d;
    logic [DATA_W-1:0]   data1_q,  data1_d;
    logic [DATA_W-1:0]   data2_q,  data2_d;
    logic [DATA_W-1:0]   imm_q,    imm_d;
    logic [PC_W-1:0]     pc_q,     pc_d;
    logic                halted_q, halted_d;

    logic  load_use;
    logic  halt_pend;
    logic  load_bubble;
    logic  load_id;
    ctrl_t id_ctrl;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_halt_i      (ctrl_q.halt),
        .ex_rd_i        (rd_q),
        .id_valid_i     (IdValid),
        .id_rs_i        (IdRs),
        .id_rt_i        (IdRt),
        .branch_taken_i (BranchTaken),
        .halted_i       (halted_q),
        .load_use_o     (load_use),
        .halt_pend_o    (halt_pend),
        .hazard_stall_o (HazardStall)
    );

    assign id_ctrl = gate_ctrl('{reg_write: RegWrite, branch: Branch, jump: Jump, halt: Halt,
                                 write_op2: WriteOP2, mem_read: MemRead, aluop: ALUOP},
                               IdValid);

    // Priority: flush, halted, downstream hold, halt drain, load-use bubble, normal load.
    always_comb begin
        load_bubble = 1'b0;
        load_id     = 1'b0;
        halted_d    = halted_q;
        if (BranchTaken) begin
            load_bubble = 1'b1;
        end else if (halted_q) begin
            load_bubble = 1'b1;
        end else if (ExStall) begin
            load_bubble = 1'b0;
        end else if (halt_pend) begin
            load_bubble = 1'b1;
            halted_d    = 1'b1;
        end else if (load_use) begin
            load_bubble = 1'b1;
        end else begin
            load_id = 1'b1;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        rd_d     = rd_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        if (load_bubble) begin
            valid_d  = 1'b0;
            ctrl_d   = BUBBLE;
            opcode_d = '0;
            funct_d  = '0;
            rd_d     = '0;
            data1_d  = '0;
            data2_d  = '0;
            imm_d    = '0;
            pc_d     = '0;
        end else if (load_id) begin
            valid_d  = IdValid;
            ctrl_d   = id_ctrl;
            opcode_d = IdOpcode;
            funct_d  = IdFunct;
            rd_d     = IdRd;
            data1_d  = IdData1;
            data2_d  = IdData2;
            imm_d    = IdImm;
            pc_d     = IdPC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= BUBBLE;
            opcode_q <= '0;
            funct_q  <= '0;
            rd_q     <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            rd_q     <= rd_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

`ifdef BUBBLE_CNT_EN
    logic        bubble_evt;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Only flushes and load-use bubbles are counted; halt-related bubbles are not.
    assign bubble_evt = BranchTaken | (~halted_q & ~ExStall & ~halt_pend & load_use);

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCount = bubble_cnt_q;
`endif

    assign ExValid    = valid_q;
    assign ExOpcode   = opcode_q;
    assign ExFunct    = funct_q;
    assign ExALUOP    = ctrl_q.aluop;
    assign ExRd       = rd_q;
    assign ExData1    = data1_q;
    assign ExData2    = data2_q;
    assign ExImm      = imm_q;
    assign ExPC       = pc_q;
    assign ExRegWrite = ctrl_q.reg_write;
    assign ExBranch   = ctrl_q.branch;
    assign ExJump     = ctrl_q.jump;
    assign ExHalt     = ctrl_q.halt;
    assign ExWriteOP2 = ctrl_q.write_op2;
    assign ExMemRead  = ctrl_q.mem_read;
    assign Halted     = halted_q;

endmodule
